// File: rtl/operand_entry.sv
// Push-button operand entry for the switch calculator: two debounced keys drive an
// A -> B -> opcode -> show FSM. Optional macro DIV_ZERO_GUARD_EN rejects div/mod by zero.
module operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [6:0] iSW,
    input  logic [1:0] iOPSW,
    input  logic [1:0] iKEY_N,
    output logic [6:0] oA,
    output logic [6:0] oB,
    output logic [1:0] oOP,
    output logic       oVALID,
    output logic [1:0] oSTATE,
    output logic       oERR
);

    localparam int unsigned OPND_W = 7;
    localparam int unsigned KEYS   = 2;
    localparam logic [OPND_W-1:0] OPND_MAX = OPND_W'(99);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    function automatic logic [OPND_W-1:0] clip(input logic [OPND_W-1:0] x);
        return (x > OPND_MAX) ? OPND_MAX : x;
    endfunction

    logic [KEYS-1:0]  sync1;
    logic [KEYS-1:0]  sync2;
    logic [KEYS-1:0]  stable;
    logic [CNT_W-1:0] cnt [KEYS];
    logic [KEYS-1:0]  take_c;
    logic [KEYS-1:0]  press_c;

    // A key level is accepted once the sampled level has differed from the stable one long enough
    always_comb begin
        take_c  = '0;
        press_c = '0;
        for (int k = 0; k < KEYS; k++) begin
            take_c[k]  = (sync2[k] != stable[k]) && (cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1));
            press_c[k] = take_c[k] && !sync2[k];
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            for (int k = 0; k < KEYS; k++) cnt[k] <= '0;
        end else begin
            sync1 <= iKEY_N;
            sync2 <= sync1;
            for (int k = 0; k < KEYS; k++) begin
                if ((sync2[k] == stable[k]) || take_c[k]) cnt[k] <= '0;
                else                                      cnt[k] <= cnt[k] + CNT_W'(1);
                if (take_c[k]) stable[k] <= sync2[k];
            end
        end
    end

    logic enter_ev;
    logic clear_ev;
    assign enter_ev = press_c[0];
    assign clear_ev = press_c[1];

    state_t            state_q;
    state_t            state_d;
    logic [OPND_W-1:0] a_d;
    logic [OPND_W-1:0] b_d;
    logic [1:0]        op_d;
    logic              err_d;

    // Clear has priority over enter when both events land together
    always_comb begin
        state_d = state_q;
        a_d     = oA;
        b_d     = oB;
        op_d    = oOP;
        err_d   = 1'b0;
        if (clear_ev) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else if (enter_ev) begin
            case (state_q)
                S_A: begin
                    a_d     = clip(iSW);
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = clip(iSW);
                    state_d = S_OP;
                end
                S_OP: begin
`ifdef DIV_ZERO_GUARD_EN
                    if ((iOPSW == 2'b11) && (oB == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = iOPSW;
                        state_d = S_SHOW;
                    end
`else
                    op_d    = iOPSW;
                    state_d = S_SHOW;
`endif
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_A;
            oA      <= '0;
            oB      <= '0;
            oOP     <= '0;
            oVALID  <= 1'b0;
            oERR    <= 1'b0;
        end else begin
            state_q <= state_d;
            oA      <= a_d;
            oB      <= b_d;
            oOP     <= op_d;
            oVALID  <= (state_d == S_SHOW);
            oERR    <= err_d;
        end
    end

    assign oSTATE = state_q;

endmodule
